// File: rtl/hier_node_sequencer_if.sv
// Start/done handshake bundle between a hierarchy node, its parent and its children.
// With HIER_SEQ_SKIP_EN defined the bundle also carries the per-child enable vector.
interface hier_node_sequencer_if #(
    parameter int NUM_CHILDREN = 5,
    parameter int IDX_W        = (NUM_CHILDREN > 1) ? $clog2(NUM_CHILDREN) : 1
);
    logic                    start;
    logic                    mode;
    logic [NUM_CHILDREN-1:0] child_done;
`ifdef HIER_SEQ_SKIP_EN
    logic [NUM_CHILDREN-1:0] child_en;
`endif
    logic [NUM_CHILDREN-1:0] child_start;
    logic                    busy;
    logic                    done;
    logic                    timeout_err;
    logic [NUM_CHILDREN-1:0] done_mask;
    logic [IDX_W-1:0]        cur_idx;

`ifdef HIER_SEQ_SKIP_EN
    modport master (
        output start, mode, child_done, child_en,
        input  child_start, busy, done, timeout_err, done_mask, cur_idx
    );
    modport slave (
        input  start, mode, child_done, child_en,
        output child_start, busy, done, timeout_err, done_mask, cur_idx
    );
`else
    modport master (
        output start, mode, child_done,
        input  child_start, busy, done, timeout_err, done_mask, cur_idx
    );
    modport slave (
        input  start, mode, child_done,
        output child_start, busy, done, timeout_err, done_mask, cur_idx
    );
`endif
endinterface

// File: rtl/hier_node_sequencer.sv
// Hierarchy node sequencer: launches NUM_CHILDREN children serially or in
// parallel, tracks their completion and aborts a launch that waits too long.
// Optional macro HIER_SEQ_SKIP_EN adds child_en; disabled children are never
// launched and count as already complete.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; child_done ignored
// LAUNCH | one cycle, child_start pulse(s) on the output
// WAIT   | sampling child_done, timeout counter running down
// FINISH | one cycle, done pulse on the output
module hier_node_sequencer #(
    parameter int NUM_CHILDREN   = 5,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int IDX_W          = (NUM_CHILDREN > 1) ? $clog2(NUM_CHILDREN) : 1,
    parameter int TMO_W          = $clog2(TIMEOUT_CYCLES)
) (
    input  logic                 clk,
    input  logic                 rst,
    hier_node_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    // The timer runs down from here; reaching zero inside WAIT is the last allowed cycle.
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t                  state_q, state_d;
    logic                    mode_q, mode_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic [NUM_CHILDREN-1:0] mask_q, mask_d;
    logic                    err_q, err_d;
    logic [NUM_CHILDREN-1:0] child_start_q, child_start_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [NUM_CHILDREN-1:0] en_in, en_q, en_d;
    logic [NUM_CHILDREN-1:0] mask_upd;
    logic [IDX_W:0]          first_en, next_en;

    // {found, index} of the lowest enabled child at or above position from.
    function automatic logic [IDX_W:0] find_en(input logic [NUM_CHILDREN-1:0] en, input int from);
        logic [IDX_W:0] res;
        res = '0;
        for (int i = NUM_CHILDREN - 1; i >= 0; i--) begin
            if (en[i] && (i >= from)) begin
                res = {1'b1, IDX_W'(i)};
            end
        end
        return res;
    endfunction

`ifdef HIER_SEQ_SKIP_EN
    assign en_in = bus.child_en;

    // Enable vector is captured with the accepted start and held for the run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q <= '0;
        end else begin
            en_q <= en_d;
        end
    end
`else
    assign en_in = '1;
    assign en_q  = '1;
`endif

    // Next-state and next-output decode; every output is registered from these.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        idx_d    = idx_q;
        tmo_d    = tmo_q;
        mask_d   = mask_q;
        err_d    = err_q;
        en_d     = en_q;
        mask_upd = mask_q | bus.child_done;
        first_en = find_en(en_in, 0);
        next_en  = find_en(en_q, int'(idx_q) + 1);

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    mode_d = bus.mode;
                    en_d   = en_in;
                    err_d  = 1'b0;
                    mask_d = ~en_in;
                    idx_d  = '0;
                    if (!first_en[IDX_W]) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_LAUNCH;
                        if (!bus.mode) begin
                            idx_d = first_en[IDX_W-1:0];
                        end
                    end
                end
            end
            ST_LAUNCH: begin
                tmo_d   = TMO_LOAD;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mode_q) begin
                    mask_d = mask_upd;
                    if (&mask_upd) begin
                        state_d = ST_FINISH;
                    end
                end else if (bus.child_done[idx_q]) begin
                    mask_d[idx_q] = 1'b1;
                    if (next_en[IDX_W]) begin
                        idx_d   = next_en[IDX_W-1:0];
                        state_d = ST_LAUNCH;
                    end else begin
                        state_d = ST_FINISH;
                    end
                end
                // Completion in the expiry cycle wins: only a still-waiting launch times out.
                if (state_d == ST_WAIT) begin
                    if (tmo_q == '0) begin
                        err_d   = 1'b1;
                        state_d = ST_FINISH;
                    end else begin
                        tmo_d = tmo_q - TMO_W'(1);
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d        = (state_d != ST_IDLE);
        done_d        = (state_d == ST_FINISH);
        child_start_d = '0;
        if (state_d == ST_LAUNCH) begin
            child_start_d = mode_d ? en_d : (NUM_CHILDREN'(1) << idx_d);
        end
    end

    // State and registered outputs; reset aborts a run without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            mode_q        <= 1'b0;
            idx_q         <= '0;
            tmo_q         <= '0;
            mask_q        <= '0;
            err_q         <= 1'b0;
            child_start_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            idx_q         <= idx_d;
            tmo_q         <= tmo_d;
            mask_q        <= mask_d;
            err_q         <= err_d;
            child_start_q <= child_start_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign bus.child_start = child_start_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.timeout_err = err_q;
    assign bus.done_mask   = mask_q;
    assign bus.cur_idx     = idx_q;
endmodule

// File: tb/tb_hier_node_sequencer.sv
// Bench for hier_node_sequencer: per-run schedule predicted from child response
// delays, directed scenarios plus randomized runs with stray inputs.
module tb_hier_node_sequencer;
    localparam int N    = 5;
    localparam int TMO  = 16;
    localparam int MAXC = 128;
    localparam logic [N-1:0] ALL_EN = '1;

    logic clk;
    logic rst;

    hier_node_sequencer_if #(.NUM_CHILDREN(N)) bus ();
    hier_node_sequencer #(.NUM_CHILDREN(N), .TIMEOUT_CYCLES(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Per-run prediction, indexed by cycle relative to the start cycle (0).
    logic [N-1:0] exp_cs [MAXC];
    int           exp_idx [MAXC];
    int           wait_child [MAXC];
    int           done_at [N];
    bit           counted [N];
    int           dly [N];
    int           fin;
    bit           exp_err;
    logic [N-1:0] preset;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // dly[k]: cycles from child k's start to its done pulse; 0 or > TMO = never answers.
    task automatic build_model(input bit mode, input logic [N-1:0] en);
        int l;
        int last;
        bit all_ok;
        for (int c = 0; c < MAXC; c++) begin
            exp_cs[c]     = '0;
            exp_idx[c]    = -1;
            wait_child[c] = -1;
        end
        for (int k = 0; k < N; k++) begin
            done_at[k] = -1;
            counted[k] = 1'b0;
        end
        exp_err = 1'b0;
        preset  = ~en;
        if (en == '0) begin
            fin = 1;
        end else if (!mode) begin
            l   = 1;
            fin = -1;
            for (int k = 0; k < N; k++) begin
                if (en[k] && fin < 0) begin
                    exp_cs[l][k] = 1'b1;
                    if (dly[k] >= 1 && dly[k] <= TMO) begin
                        for (int c = l; c <= l + dly[k]; c++) exp_idx[c] = k;
                        for (int c = l + 1; c <= l + dly[k]; c++) wait_child[c] = k;
                        done_at[k] = l + dly[k];
                        counted[k] = 1'b1;
                        l = l + dly[k] + 1;
                    end else begin
                        for (int c = l; c <= l + TMO; c++) exp_idx[c] = k;
                        for (int c = l + 1; c <= l + TMO; c++) wait_child[c] = k;
                        exp_err = 1'b1;
                        fin = l + TMO + 1;
                    end
                end
            end
            if (fin < 0) fin = l;
        end else begin
            exp_cs[1] = en;
            all_ok = 1'b1;
            last   = 0;
            for (int k = 0; k < N; k++) begin
                if (en[k]) begin
                    if (dly[k] >= 1 && dly[k] <= TMO) begin
                        done_at[k] = 1 + dly[k];
                        counted[k] = 1'b1;
                        if (1 + dly[k] > last) last = 1 + dly[k];
                    end else begin
                        all_ok = 1'b0;
                    end
                end
            end
            fin = all_ok ? last + 1 : TMO + 2;
            exp_err = !all_ok;
            for (int c = 1; c <= fin + 1; c++) exp_idx[c] = 0;
        end
    endtask

    task automatic drive_cycle(input int c, input bit mode, input logic [N-1:0] en, input bit stray);
        logic [N-1:0] cd;
        bus.start = (c == 0);
        if (stray && c >= 1 && c <= fin && ($urandom_range(0, 4) == 0 || c == 4)) bus.start = 1'b1;
        bus.mode = (c == 0) ? mode : 1'($urandom);
`ifdef HIER_SEQ_SKIP_EN
        bus.child_en = (c == 0) ? en : N'($urandom);
`endif
        cd = '0;
        for (int k = 0; k < N; k++) if (done_at[k] == c) cd[k] = 1'b1;
        if (stray && (c == 0 || !mode)) begin
            for (int j = 0; j < N; j++) begin
                if (j != wait_child[c] && ($urandom_range(0, 5) == 0 || (c == 2 && j == 3)))
                    cd[j] = 1'b1;
            end
        end
        bus.child_done = cd;
    endtask

    task automatic run_case(input bit mode, input logic [N-1:0] en, input bit stray, output int got_fin);
        logic [N-1:0] m;
        build_model(mode, en);
        got_fin = -1;
        for (int c = 0; c <= fin + 1; c++) begin
            @(posedge clk);
            #1;
            if (c >= 1) begin
                m = preset;
                for (int k = 0; k < N; k++) if (counted[k] && done_at[k] < c) m[k] = 1'b1;
                check("child_start", 32'(bus.child_start), 32'(exp_cs[c]));
                check("busy", 32'(bus.busy), 32'(c <= fin));
                check("done", 32'(bus.done), 32'(c == fin));
                check("done_mask", 32'(bus.done_mask), 32'(m));
                check("timeout_err", 32'(bus.timeout_err), 32'(exp_err && c >= fin));
                if (exp_idx[c] >= 0) check("cur_idx", 32'(bus.cur_idx), 32'(exp_idx[c]));
                if (bus.done === 1'b1 && got_fin < 0) got_fin = c;
            end
            drive_cycle(c, mode, en, stray);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f;
        int ndone;
        logic [N-1:0] en;
        bit mode;

        rst = 1'b1;
        bus.start = 1'b0;
        bus.mode = 1'b0;
        bus.child_done = '0;
`ifdef HIER_SEQ_SKIP_EN
        bus.child_en = '1;
`endif
        #1;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_mask", 32'(bus.done_mask), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Serial, 3-cycle responses.
        for (int k = 0; k < N; k++) dly[k] = 3;
        run_case(1'b0, ALL_EN, 1'b0, f);
        check("serial_done_cycle", 32'(f), 32'd21);

        // Parallel with staggered completions.
        dly[0] = 2; dly[1] = 2; dly[2] = 5; dly[3] = 1; dly[4] = 8;
        run_case(1'b1, ALL_EN, 1'b0, f);
        check("parallel_done_cycle", 32'(f), 32'd10);

        // Serial with child 2 silent: timeout, then next start clears the flag.
        for (int k = 0; k < N; k++) dly[k] = 3;
        dly[2] = 0;
        run_case(1'b0, ALL_EN, 1'b0, f);
        check("timeout_done_cycle", 32'(f), 32'd26);
        check("timeout_mask", 32'(bus.done_mask), 32'h03);
        for (int k = 0; k < N; k++) dly[k] = 3;
        run_case(1'b0, ALL_EN, 1'b0, f);
        check("after_timeout_done_cycle", 32'(f), 32'd21);

        // Reset during child 1's WAIT.
        build_model(1'b0, ALL_EN);
        for (int c = 0; c <= 6; c++) begin
            @(posedge clk);
            #1;
            if (c == 6) begin
                check("pre_reset_busy", 32'(bus.busy), 32'd1);
                check("pre_reset_idx", 32'(bus.cur_idx), 32'd1);
            end else begin
                drive_cycle(c, 1'b0, ALL_EN, 1'b0);
            end
        end
        rst = 1'b1;
        #1;
        check("mid_reset_busy", 32'(bus.busy), 32'd0);
        check("mid_reset_child_start", 32'(bus.child_start), 32'd0);
        check("mid_reset_mask", 32'(bus.done_mask), 32'd0);
        check("mid_reset_idx", 32'(bus.cur_idx), 32'd0);
        bus.child_done = '0;
        bus.start = 1'b0;
        ndone = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
        end
        check("post_reset_quiet", 32'(ndone), 32'd0);
        run_case(1'b0, ALL_EN, 1'b0, f);
        check("post_reset_done_cycle", 32'(f), 32'd21);

        // Stray start at T+4 and stray child_done[3] during child 0's WAIT.
        run_case(1'b0, ALL_EN, 1'b1, f);
        check("stray_done_cycle", 32'(f), 32'd21);

`ifdef HIER_SEQ_SKIP_EN
        run_case(1'b0, N'(5'b10101), 1'b0, f);
        check("skip_done_cycle", 32'(f), 32'd13);
        run_case(1'b0, '0, 1'b0, f);
        check("skip_none_done_cycle", 32'(f), 32'd1);
        check("skip_none_mask", 32'(bus.done_mask), 32'(ALL_EN));
`endif

        // Randomized runs.
        for (int r = 0; r < 40; r++) begin
            mode = 1'($urandom);
`ifdef HIER_SEQ_SKIP_EN
            en = N'($urandom);
`else
            en = ALL_EN;
`endif
            for (int k = 0; k < N; k++)
                dly[k] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TMO));
            run_case(mode, en, 1'($urandom), f);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/hier_node_sequencer.md
Name: hier_node_sequencer

Overview:
- Parametrised hierarchy node that owns NUM_CHILDREN child instances and sequences their start/done handshakes.
- Successor to the fixed, port-less five-child hierarchy node: child count is a parameter, and the node adds run control, serial/parallel launch modes, completion tracking and a per-launch timeout.
- Sits at any level of the generated module tree, between its parent's start/done pair and its children's start/done pairs.

Parameters:
- NUM_CHILDREN, 5, number of child instances sequenced; must be >= 1.
- TIMEOUT_CYCLES, 16, maximum number of WAIT cycles per launch before abort; must be >= 2.
- IDX_W, $clog2(NUM_CHILDREN) with a minimum of 1, width of cur_idx.
- TMO_W, $clog2(TIMEOUT_CYCLES), width of the timeout counter.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  asynchronous reset, active high.
- start  in  1  run request pulse; sampled only in IDLE.
- mode  in  1  0 = serial launch, 1 = parallel launch; sampled together with start.
- child_done  in  NUM_CHILDREN  per-child completion level or pulse.
- child_start  out  NUM_CHILDREN  per-child one-cycle launch pulse.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a run ends, whether normally or by timeout.
- timeout_err  out  1  sticky abort flag; cleared by the next accepted start.
- done_mask  out  NUM_CHILDREN  sticky record of which children have completed in the current run.
- cur_idx  out  IDX_W  index of the child currently launched in serial mode; 0 in parallel mode.

Behaviour:
- Reset (asynchronous, active high): FSM goes to IDLE; every output, the latched mode, the index and the timeout counter clear to 0 immediately. Reset asserted mid-run aborts the run with no done pulse.
- States:
  - IDLE: wait for start.
  - LAUNCH: one cycle; drive child_start for the current child (serial) or all children (parallel).
  - WAIT: sample child_done; count toward timeout.
  - FINISH: one cycle; drive done.
- IDLE: if start=1, latch mode, clear done_mask, clear timeout_err, set idx=0, go to LAUNCH. child_done is ignored while in IDLE.
- LAUNCH:
  - Serial: child_start = one-hot(idx).
  - Parallel: child_start = all ones.
  - Clear the timeout counter; go to WAIT.
  - child_done is not sampled in LAUNCH; a child must respond at least 1 cycle after its start.
- WAIT, serial mode:
  - Only child_done[idx] counts; done bits from other children are ignored and do not set done_mask.
  - On child_done[idx]=1: set done_mask[idx]. If idx == NUM_CHILDREN-1, go to FINISH; otherwise idx+1, go to LAUNCH.
- WAIT, parallel mode:
  - Each cycle, done_mask |= child_done.
  - Completion when the updated mask is all ones; this includes several children finishing in the same cycle. Go to FINISH.
- Timeout: the counter increments on every WAIT cycle without completion. If it equals TIMEOUT_CYCLES-1 and completion has not occurred, set timeout_err=1 and go to FINISH, keeping the partial done_mask. Completion and expiry in the same cycle count as completion.
- FINISH: done=1 for one cycle, then IDLE. done_mask and timeout_err hold until the next accepted start.
- start while busy is ignored, with no queuing. start in the FINISH cycle is ignored.
- Latency: with start sampled at cycle T, the first child_start is at T+1. Serial mode: each child costs 1 + (response delay) cycles. done appears the cycle after the final completion.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro HIER_SEQ_SKIP_EN adds input child_en [NUM_CHILDREN], latched on the accepted start.
- Children with a latched enable of 0 are never launched and have their done_mask bit preset to 1 at start.
  - Serial mode: idx advances directly to the next enabled child, with no LAUNCH cycle spent on disabled ones.
  - Parallel mode: child_start is driven with the enable mask.
- If all children are disabled, IDLE goes straight to FINISH: done pulses at T+1 and done_mask is all ones.
- Without the macro: the port is absent and all children are always enabled.

Test Plan:
- Serial run (NUM_CHILDREN=5, TIMEOUT_CYCLES=16), start at T, each child's done pulses 3 cycles after its start -> child_start walks 00001..10000 at T+1, T+5, T+9, T+13, T+17; done at T+21; done_mask=11111; timeout_err=0.
- Parallel run, child_done for children 0..4 at T+3, T+3, T+6, T+2, T+9 -> child_start=11111 at T+1 only; done_mask=01011 at T+3; done at T+10.
- Serial run with child 2 never responding -> its LAUNCH at T+9, WAIT T+10..T+25; timeout_err=1 and done at T+26; done_mask=00011; next start clears both.
- Reset asserted during WAIT of child 1 -> busy, child_start, done_mask and cur_idx read 0 in the same cycle; no done pulse; a new start after reset behaves as the first scenario.
- start pulsed at T+4 during a run, and stray child_done[3] during child 0's WAIT -> both ignored; the run timing matches the first scenario; done_mask[3] is set only after child 3's own completion.
- With HIER_SEQ_SKIP_EN, child_en=10101 in serial mode with 3-cycle responses -> child_start 00001, 00100, 10000 at T+1, T+5, T+9; done at T+13; done_mask=11111. With child_en=00000 -> done at T+1.
